// File: rtl/imm_pkg.sv
// Shared immediate-format types, field masks and the scatter helper used by the encoder.
// The format enum is shared with the decode path, so its encoding must not change.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_PACK  = 2'b10,
    ST_DONE  = 2'b11
  } enc_state_t;

  localparam logic [31:0] MASK_I = 32'hFFF00000;
  localparam logic [31:0] MASK_S = 32'hFE000F80;
  localparam logic [31:0] MASK_B = 32'hFE000F80;
  localparam logic [31:0] MASK_J = 32'hFFFFF000;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [31:0] imm_mask(input imm_src_t src);
    logic [31:0] m;
    m = MASK_I;
    case (src)
      IMM_I:   m = MASK_I;
      IMM_S:   m = MASK_S;
      IMM_B:   m = MASK_B;
      IMM_J:   m = MASK_J;
      default: m = MASK_I;
    endcase
    return m;
  endfunction

  // Places immediate bits at their instruction positions; non-field bits are zero.
  function automatic logic [31:0] imm_scatter(input imm_src_t src, input logic [31:0] imm);
    logic [31:0] f;
    f = '0;
    case (src)
      IMM_I:   f = {imm[11:0], 20'b0};
      IMM_S:   f = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      IMM_B:   f = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      IMM_J:   f = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational representability check: bit0 = range error, bit1 = misalignment.
// Range holds when every bit above the format's top immediate bit matches the sign.
module imm_range_check
  import imm_pkg::*;
(
  input  logic [31:0] imm,
  input  imm_src_t    ImmSrc,
  output logic [1:0]  err_code
);

  logic range_err;
  logic misalign_err;
  logic unused_imm_bits;

  assign unused_imm_bits = ^imm[10:1];

  always_comb begin
    range_err    = 1'b0;
    misalign_err = 1'b0;
    case (ImmSrc)
      IMM_I, IMM_S: range_err = !((&imm[31:11]) || !(|imm[31:11]));
      IMM_B: begin
        range_err    = !((&imm[31:12]) || !(|imm[31:12]));
        misalign_err = imm[0];
      end
      IMM_J: begin
        range_err    = !((&imm[31:20]) || !(|imm[31:20]));
        misalign_err = imm[0];
      end
      default: begin
        range_err    = 1'b0;
        misalign_err = 1'b0;
      end
    endcase
  end

  assign err_code = {misalign_err, range_err};

endmodule

// File: rtl/instr_imm_encoder.sv
// Four-state immediate packer: accept -> CHECK -> PACK -> DONE, out_valid two edges after accept.
// Results and status hold in DONE until out_ready; in_ready is high only in IDLE.
module instr_imm_encoder
  import imm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] base_instr,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_out,
  output logic        imm_err,
  output logic [1:0]  err_code,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  enc_state_t  state_q, state_d;
  imm_src_t    src_q, src_d;
  logic [31:0] base_q, base_d;
  logic [31:0] imm_q, imm_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] instr_q, instr_d;
  logic        imm_err_q, imm_err_d;
  logic [15:0] enc_count_q, enc_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [1:0]  chk_err;

  imm_range_check u_range_check (
    .imm      (imm_q),
    .ImmSrc   (src_q),
    .err_code (chk_err)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_PACK;
      ST_PACK:  state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    src_d       = src_q;
    base_d      = base_q;
    imm_d       = imm_q;
    err_code_d  = err_code_q;
    instr_d     = instr_q;
    imm_err_d   = imm_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        src_d  = imm_src_t'(ImmSrc);
        base_d = base_instr;
        imm_d  = imm;
      end
      ST_CHECK: err_code_d = chk_err;
      // On error the immediate fields are cleared rather than partially filled.
      ST_PACK: begin
        imm_err_d = |err_code_q;
        instr_d   = (base_q & ~imm_mask(src_q))
                  | ((|err_code_q) ? 32'h0 : imm_scatter(src_q, imm_q));
      end
      ST_DONE: if (out_ready) begin
        if (enc_count_q != CNT_MAX) enc_count_d = enc_count_q + 16'd1;
        if (imm_err_q && (err_count_q != CNT_MAX)) err_count_d = err_count_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q       <= IMM_I;
      base_q      <= '0;
      imm_q       <= '0;
      err_code_q  <= '0;
      instr_q     <= '0;
      imm_err_q   <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      src_q       <= src_d;
      base_q      <= base_d;
      imm_q       <= imm_d;
      err_code_q  <= err_code_d;
      instr_q     <= instr_d;
      imm_err_q   <= imm_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign instr_out = instr_q;
  assign imm_err   = imm_err_q;
  assign err_code  = err_code_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule
